// File: rtl/float_params.sv
// Shared IEEE-754 single-precision constants and types for the float adder and multiplier.
// FLOAT_ADD_ROUND_EN adds guard/round/sticky bits to the adder mantissa datapath.
package float_params;

   localparam int unsigned EXPONENT_WIDTH = 8;
   localparam int unsigned MANTISSA_WIDTH = 23;
   localparam int unsigned BIAS           = 127;
   localparam logic [EXPONENT_WIDTH-1:0] EXP_MAX = 8'hFF;

`ifdef FLOAT_ADD_ROUND_EN
   localparam int unsigned GRS_BITS = 3;
`else
   localparam int unsigned GRS_BITS = 0;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UNPACK,
      ST_ALIGN,
      ST_ADD,
      ST_NORMALIZE,
      ST_PACK
   } float_add_state_t;

   // mant carries the implicit leading one; zero operands hold mant = 0
   typedef struct packed {
      logic                      sign;
      logic [EXPONENT_WIDTH-1:0] exp;
      logic [MANTISSA_WIDTH:0]   mant;
   } float_unpacked_t;

   function automatic float_unpacked_t float_unpack(input logic [31:0] f);
      float_unpacked_t u;
      u.sign = f[31];
      u.exp  = f[30:23];
      u.mant = (u.exp == '0) ? '0 : {1'b1, f[22:0]};
      return u;
   endfunction

endpackage

// File: rtl/float_align_shift.sv
// Combinational mantissa right shifter; shifts of 26 or more clear the result.
// o_sticky (OR of all discarded bits) exists only when FLOAT_ADD_ROUND_EN is defined.
module float_align_shift #(
   parameter int unsigned W = 24
) (
   input  logic [W-1:0] i_mant,
   input  logic [7:0]   i_shift,
`ifdef FLOAT_ADD_ROUND_EN
   output logic         o_sticky,
`endif
   output logic [W-1:0] o_mant
);

   always_comb begin
      o_mant = '0;
      if (i_shift < 8'd26) begin
         o_mant = i_mant >> i_shift;
      end
   end

`ifdef FLOAT_ADD_ROUND_EN
   logic [W-1:0] w_ones;
   logic [W-1:0] w_mask;

   always_comb begin
      w_ones   = '1;
      w_mask   = ~(w_ones << i_shift);
      o_sticky = (i_shift >= 8'd26) ? (|i_mant) : (|(i_mant & w_mask));
   end
`endif

endmodule

// File: rtl/float_add_pipeline.sv
// Multi-cycle single-precision adder with req/ack handshake (normal operands, truncation).
// Define FLOAT_ADD_ROUND_EN for guard/round/sticky tracking and round-to-nearest-even.
module float_add_pipeline
   import float_params::*;
#(
   parameter int unsigned float_width = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req,
   output logic                   ack,
   input  logic [float_width-1:0] a,
   input  logic [float_width-1:0] b,
   output logic [float_width-1:0] out
);

   localparam int unsigned DW = MANTISSA_WIDTH + 1 + GRS_BITS;

   float_add_state_t            r_state;
   logic [float_width-1:0]      r_a;
   logic [float_width-1:0]      r_b;
   logic [float_width-1:0]      r_out;
   logic                        r_ack;
   float_unpacked_t             r_x;
   float_unpacked_t             r_y;
   logic [DW-1:0]               r_my;
   logic                        r_sign;
   logic [EXPONENT_WIDTH:0]     r_exp;
   logic [DW:0]                 r_mant;

   float_unpacked_t             w_ua;
   float_unpacked_t             w_ub;
   logic                        w_a_big;
   logic [7:0]                  w_diff;
   logic [DW-1:0]               w_my_in;
   logic [DW-1:0]               w_my_sh;
   logic [DW:0]                 w_mx;
   logic [DW:0]                 w_mant_rsh;
   logic [EXPONENT_WIDTH:0]     w_pack_exp;
   logic [MANTISSA_WIDTH-1:0]   w_pack_frac;

   assign w_ua    = float_unpack(r_a);
   assign w_ub    = float_unpack(r_b);
   assign w_a_big = (w_ua.exp > w_ub.exp) ||
                    ((w_ua.exp == w_ub.exp) && (w_ua.mant >= w_ub.mant));

   assign w_diff  = r_x.exp - r_y.exp;
   assign w_my_in = DW'(r_y.mant) << GRS_BITS;
   assign w_mx    = (DW+1)'(r_x.mant) << GRS_BITS;

`ifdef FLOAT_ADD_ROUND_EN
   logic                      w_sticky;
   logic                      w_round_up;
   logic [MANTISSA_WIDTH+1:0] w_rnd;

   float_align_shift #(.W(DW)) u_align (
      .i_mant   (w_my_in),
      .i_shift  (w_diff),
      .o_sticky (w_sticky),
      .o_mant   (w_my_sh)
   );

   // the bit dropped by a carry renormalize folds into sticky
   assign w_mant_rsh = (r_mant >> 1) | (DW+1)'(r_mant[0]);

   always_comb begin
      w_round_up = r_mant[GRS_BITS-1] &
                   (r_mant[GRS_BITS-2] | r_mant[GRS_BITS-3] | r_mant[GRS_BITS]);
      w_rnd      = {1'b0, r_mant[DW-1:GRS_BITS]} + (MANTISSA_WIDTH+2)'(w_round_up);
      if (w_rnd[MANTISSA_WIDTH+1]) begin
         w_pack_exp  = r_exp + 9'd1;
         w_pack_frac = w_rnd[MANTISSA_WIDTH:1];
      end else begin
         w_pack_exp  = r_exp;
         w_pack_frac = w_rnd[MANTISSA_WIDTH-1:0];
      end
   end
`else
   float_align_shift #(.W(DW)) u_align (
      .i_mant  (w_my_in),
      .i_shift (w_diff),
      .o_mant  (w_my_sh)
   );

   assign w_mant_rsh  = r_mant >> 1;
   assign w_pack_exp  = r_exp;
   assign w_pack_frac = r_mant[MANTISSA_WIDTH-1:0];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_out   <= '0;
         r_ack   <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_my    <= '0;
         r_sign  <= 1'b0;
         r_exp   <= '0;
         r_mant  <= '0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_state <= ST_UNPACK;
               end
            end
            ST_UNPACK: begin
               r_x     <= w_a_big ? w_ua : w_ub;
               r_y     <= w_a_big ? w_ub : w_ua;
               r_state <= ST_ALIGN;
            end
            ST_ALIGN: begin
`ifdef FLOAT_ADD_ROUND_EN
               r_my    <= w_my_sh | DW'(w_sticky);
`else
               r_my    <= w_my_sh;
`endif
               r_sign  <= r_x.sign;
               r_exp   <= {1'b0, r_x.exp};
               r_state <= ST_ADD;
            end
            ST_ADD: begin
               if (r_x.sign == r_y.sign) begin
                  r_mant <= w_mx + (DW+1)'(r_my);
               end else begin
                  r_mant <= w_mx - (DW+1)'(r_my);
               end
               r_state <= ST_NORMALIZE;
            end
            ST_NORMALIZE: begin
               if (r_mant[DW]) begin
                  r_mant  <= w_mant_rsh;
                  r_exp   <= r_exp + 9'd1;
                  r_state <= ST_PACK;
               end else if (r_mant == '0) begin
                  r_sign  <= 1'b0;
                  r_exp   <= '0;
                  r_state <= ST_PACK;
               end else if (r_mant[DW-1]) begin
                  r_state <= ST_PACK;
               end else if (r_exp <= 9'd1) begin
                  r_mant  <= '0;
                  r_exp   <= '0;
                  r_state <= ST_PACK;
               end else begin
                  r_mant  <= r_mant << 1;
                  r_exp   <= r_exp - 9'd1;
               end
            end
            ST_PACK: begin
               if (w_pack_exp >= {1'b0, EXP_MAX}) begin
                  r_out <= {r_sign, EXP_MAX, 23'h0};
               end else begin
                  r_out <= {r_sign, w_pack_exp[EXPONENT_WIDTH-1:0], w_pack_frac};
               end
               r_ack   <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ack = r_ack;
   assign out = r_out;

endmodule

// File: tb/tb_float_add_pipeline.sv
// Directed-vector bench for float_add_pipeline; expectations hand-computed, ack latency counted
// from the accepting edge E0. Round-sensitive vectors switch on FLOAT_ADD_ROUND_EN.
module tb_float_add_pipeline;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        ack;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] out;

   int n_total = 0;
   int n_bad   = 0;

   float_add_pipeline #(.float_width(32)) dut (
      .clk (clk),
      .rst (rst),
      .req (req),
      .ack (ack),
      .a   (a),
      .b   (b),
      .out (out)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // issue one add, count edges after E0 until ack (bounded), check result and ack width
   task automatic run_add(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] exp_out, input int exp_lat,
                          input bit at_edge, input bit chk_tail);
      int n;
      bit seen;
      if (!at_edge) @(negedge clk);
      a   = ia;
      b   = ib;
      req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (ack) seen = 1'b1;
      end
      check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
      check_eq({tag, "_out"}, out, exp_out);
      if (chk_tail) begin
         @(posedge clk);
         #1;
         check_eq({tag, "_ackw"}, 32'(ack), 32'd0);
      end
   endtask

   initial begin
      int          acks;
      int          first;
      logic [31:0] got;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ack", 32'(ack), 32'd0);
      check_eq("rst_out", out, 32'h0);
      rst = 1'b0;

      run_add("one_plus_one",  32'h3F800000, 32'h3F800000, 32'h40000000, 5, 0, 1);
      run_add("sub_k2",        32'h3FC00000, 32'hBF800000, 32'h3F000000, 6, 0, 1);
      run_add("cancel",        32'h40400000, 32'hC0400000, 32'h00000000, 5, 0, 1);
      run_add("zero_a",        32'h00000000, 32'hC0A00000, 32'hC0A00000, 5, 0, 1);
      run_add("diff30",        32'h3F800000, 32'h30800000, 32'h3F800000, 5, 0, 1);
      run_add("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 5, 0, 1);
      run_add("swap_exp",      32'h3F800000, 32'h40400000, 32'h40800000, 5, 0, 1);
      run_add("swap_mant",     32'hBF800000, 32'h3FC00000, 32'h3F000000, 6, 0, 1);
      run_add("neg_neg",       32'hC0000000, 32'hBF800000, 32'hC0400000, 5, 0, 1);
      run_add("flush",         32'h80C00000, 32'h00800000, 32'h80000000, 5, 0, 1);
`ifdef FLOAT_ADD_ROUND_EN
      run_add("round",         32'h3F800000, 32'h33C00000, 32'h3F800001, 5, 0, 1);
      run_add("long_norm",     32'h3F800000, 32'hBF7FFFFF, 32'h33800000, 29, 0, 1);
`else
      run_add("round",         32'h3F800000, 32'h33C00000, 32'h3F800000, 5, 0, 1);
      run_add("long_norm",     32'h3F800000, 32'hBF7FFFFF, 32'h34000000, 28, 0, 1);
`endif

      // back-to-back: second req presented in the cycle right after ack
      run_add("b2b_first",     32'h3F800000, 32'h3F800000, 32'h40000000, 5, 0, 0);
      run_add("b2b_second",    32'h40000000, 32'hBF000000, 32'h3FC00000, 6, 1, 1);

      // reset while in NORMALIZE aborts with no ack and clears out
      @(negedge clk);
      a   = 32'h3FC00000;
      b   = 32'hBF800000;
      req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      acks = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (ack) acks++;
      end
      check_eq("abort_acks", 32'(acks), 32'd0);
      check_eq("abort_out", out, 32'h0);
      run_add("post_rst",      32'h3F800000, 32'h3F800000, 32'h40000000, 5, 0, 1);

      // req pulsed while busy must be ignored
      @(negedge clk);
      a   = 32'h3F800000;
      b   = 32'h3F800000;
      req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      @(posedge clk);
      #1;
      a   = 32'h40400000;
      b   = 32'h40400000;
      req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      acks  = 0;
      first = 0;
      got   = '0;
      for (int e = 3; e <= 18; e++) begin
         @(posedge clk);
         #1;
         if (ack) begin
            acks++;
            if (first == 0) begin
               first = e;
               got   = out;
            end
         end
      end
      check_eq("busy_lat", 32'(first), 32'd5);
      check_eq("busy_out", got, 32'h40000000);
      check_eq("busy_acks", 32'(acks), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
